// File: rtl/instr_encoder_if.sv
// Symbolic-instruction input stream and instruction-memory write port of instr_encoder.
// slave is the encoder side; master is the producer/memory side.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [25:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic instructions into MIPS R/I/J words, buffers them in a FIFO and
// writes them sequentially into instruction memory starting at BASE_ADDR.
module instr_encoder #(
    parameter int                ADDR_W     = 10,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  bus,
    output logic            err,
    output logic            done,
    output logic [ADDR_W:0] wr_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {S_RUN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [32:0]       fifo_q [FIFO_DEPTH];
    logic [32:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              last_acc_q, last_acc_d;
    logic              bad_last_q, bad_last_d;

    logic        fifo_empty, fifo_full;
    logic [32:0] head;
    logic [31:0] enc_word;
    logic        enc_ok;
    logic        in_ready, mem_we, accept, push, pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign accept     = bus.in_valid && in_ready;
    assign push       = accept && enc_ok;
    assign pop        = mem_we && bus.mem_ready;

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        case (bus.in_op)
            5'd0:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100000};
            5'd1:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100010};
            5'd2:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100100};
            5'd3:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100101};
            5'd4:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b101010};
            5'd5:  enc_word = {6'b000000, bus.in_rs, 15'd0, 6'b001000};
            5'd6:  enc_word = 32'h0000000C;
            5'd7:  enc_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            5'd8:  enc_word = {6'b001001, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            5'd9:  enc_word = {6'b001011, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            5'd10: enc_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            5'd11: enc_word = {6'b001111, 5'd0,      bus.in_rt, bus.in_imm[15:0]};
            5'd12: enc_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            5'd13: enc_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            5'd14: enc_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            5'd15: enc_word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            5'd16: enc_word = {6'b000010, bus.in_imm};
            5'd17: enc_word = {6'b000011, bus.in_imm};
            default: enc_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // An unsupported op carrying in_last finishes once earlier words have drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:  if ((pop && head[32]) || (bad_last_q && fifo_empty)) state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_RUN) && !fifo_full && !last_acc_q;
        mem_we   = (state_q == S_RUN) && !fifo_empty;
        done     = (state_q == S_DONE);
    end

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        addr_d     = addr_q;
        count_d    = count_q;
        err_d      = err_q;
        last_acc_d = last_acc_q;
        bad_last_d = bad_last_q;
        if (push) begin
            fifo_d[wr_ptr_q[PTR_W-1:0]] = {bus.in_last, enc_word};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            addr_d   = addr_q + 1'b1;
            if (count_q != '1) count_d = count_q + 1'b1;
        end
        if (accept && bus.in_last) last_acc_d = 1'b1;
        if (accept && !enc_ok) begin
            err_d = 1'b1;
            if (bus.in_last) bad_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
            err_q      <= 1'b0;
            last_acc_q <= 1'b0;
            bad_last_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            last_acc_q <= last_acc_d;
            bad_last_q <= bad_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = fifo_empty ? '0 : head[31:0];
    assign err           = err_q;
    assign wr_count      = count_q;
endmodule
